// File: rtl/dds_load_arb_pkg.sv
// dds_load_arb_pkg: shared types and default widths for the DDS chirp load arbiter
//   state_t     : arbiter FSM states (ABORT only reachable with DDS_LOAD_TIMEOUT_EN)
//   chirp_cfg_t : one chirp programming set {freq, step, rate}
package dds_load_arb_pkg;
    localparam int DDS_FW = 48;
    localparam int DDS_RW = 32;

    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, START, DONE, ABORT} state_t;

    typedef struct packed {
        logic [DDS_FW-1:0] freq;
        logic [DDS_FW-1:0] step;
        logic [DDS_RW-1:0] rate;
    } chirp_cfg_t;
endpackage

// File: rtl/dds_load_arb_if.sv
// dds_load_arb_if: requester bus plus REQ/ACK DDS load handshake
//   master : environment side (requesters drive r_*, 96 MHz domain drives ACK)
//   slave  : arbiter side (drives grants, done pulses, DDS_* words, REQ, DDS_start)
interface dds_load_arb_if import dds_load_arb_pkg::*; #(
    parameter int FW = DDS_FW,
    parameter int RW = DDS_RW
) ();
    logic [1:0]    r_req;
    logic [1:0]    r_start;
    logic [FW-1:0] r0_freq;
    logic [FW-1:0] r1_freq;
    logic [FW-1:0] r0_step;
    logic [FW-1:0] r1_step;
    logic [RW-1:0] r0_rate;
    logic [RW-1:0] r1_rate;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic [FW-1:0] DDS_freq;
    logic [FW-1:0] DDS_delta_freq;
    logic [RW-1:0] DDS_delta_rate;
    logic          REQ;
    logic          ACK;
    logic          DDS_start;

    modport master (
        output r_req, r_start, r0_freq, r1_freq, r0_step, r1_step, r0_rate, r1_rate, ACK,
        input  r_gnt, r_done, DDS_freq, DDS_delta_freq, DDS_delta_rate, REQ, DDS_start
    );

    modport slave (
        input  r_req, r_start, r0_freq, r1_freq, r0_step, r1_step, r0_rate, r1_rate, ACK,
        output r_gnt, r_done, DDS_freq, DDS_delta_freq, DDS_delta_rate, REQ, DDS_start
    );
endinterface

// File: rtl/dds_load_arb_ack_sync.sv
// dds_load_arb_ack_sync: SYNC_STG-flop synchronizer bringing the 96 MHz ACK into the CLK domain
//   CLK   : 48 MHz system clock
//   rst_n : asynchronous active-low clear of all stages
//   ack   : asynchronous ACK from the DDS domain
//   ack_s : synchronized ACK
module dds_load_arb_ack_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic ack,
    output logic ack_s
);
    logic [SYNC_STG-1:0] sync;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STG-2:0], ack};
    end

    assign ack_s = sync[SYNC_STG-1];
endmodule

// File: rtl/dds_load_arb.sv
// dds_load_arb: two-requester arbiter sequencing the 4-phase REQ/ACK DDS load, then DDS_start
//   CLK     : 48 MHz system clock
//   rst_n   : asynchronous active-low reset
//   bus     : dds_load_arb_if.slave (requester bus, DDS_* words, REQ/ACK, DDS_start)
//   busy    : FSM not in IDLE
//   err_tmo : sticky ACK watchdog error
// Optional: define DDS_LOAD_TIMEOUT_EN to enable the per-phase ACK watchdog and ABORT state.
module dds_load_arb import dds_load_arb_pkg::*; #(
    parameter int FW       = DDS_FW,
    parameter int RW       = DDS_RW,
    parameter int SYNC_STG = 2,
    parameter int TMO_CYC  = 255
) (
    input  logic             CLK,
    input  logic             rst_n,
    dds_load_arb_if.slave    bus,
    output logic             busy,
    output logic             err_tmo
);
    state_t     state, state_nxt;
    logic       ack_s;
    logic       win, win_nxt;
    logic       start_sel, start_nxt;
    logic [1:0] guard, guard_nxt;
    logic       req_nxt;
    logic       grant;
    logic       pick1;

    dds_load_arb_ack_sync #(.SYNC_STG(SYNC_STG)) u_ack_sync (
        .CLK   (CLK),
        .rst_n (rst_n),
        .ack   (bus.ACK),
        .ack_s (ack_s)
    );

    // r0 has priority unless it has already won twice in a row while r1 was waiting
    assign pick1 = bus.r_req[1] && (!bus.r_req[0] || guard == 2'd2);
    // a stale ACK from a previous (possibly aborted) transfer blocks new grants
    assign grant = (state == IDLE) && |bus.r_req && !ack_s;
    assign busy  = state != IDLE;

`ifdef DDS_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt;
    logic          tmo;

    assign tmo = (state == LOAD || state == RELEASE) && cnt == CW'(TMO_CYC - 1);
`else
    assign err_tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        start_nxt = start_sel;
        guard_nxt = guard;
        req_nxt   = bus.REQ;
        case (state)
            IDLE: if (grant) begin
                state_nxt = LOAD;
                win_nxt   = pick1;
                start_nxt = bus.r_start[pick1];
                req_nxt   = 1'b1;
                guard_nxt = pick1 ? 2'd0 : guard + {1'b0, bus.r_req[1]};
            end
            LOAD: if (ack_s) begin
                state_nxt = RELEASE;
                req_nxt   = 1'b0;
            end
            RELEASE: if (!ack_s) state_nxt = start_sel ? START : DONE;
            START:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
`ifdef DDS_LOAD_TIMEOUT_EN
            ABORT:   if (!ack_s) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef DDS_LOAD_TIMEOUT_EN
        // an ACK edge arriving on the limit cycle still wins over the abort
        if (tmo && state_nxt == state) begin
            state_nxt = ABORT;
            req_nxt   = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            win                <= 1'b0;
            start_sel          <= 1'b0;
            guard              <= 2'd0;
            bus.REQ            <= 1'b0;
            bus.r_gnt          <= 2'b00;
            bus.r_done         <= 2'b00;
            bus.DDS_start      <= 1'b0;
            bus.DDS_freq       <= '0;
            bus.DDS_delta_freq <= '0;
            bus.DDS_delta_rate <= '0;
        end else begin
            state         <= state_nxt;
            win           <= win_nxt;
            start_sel     <= start_nxt;
            guard         <= guard_nxt;
            bus.REQ       <= req_nxt;
            // DONE lasts one cycle, so entering it marks exactly one done pulse
            bus.r_gnt     <= grant ? (pick1 ? 2'b10 : 2'b01) : (state_nxt == DONE ? 2'b00 : bus.r_gnt);
            bus.r_done    <= state_nxt == DONE ? (win ? 2'b10 : 2'b01) : 2'b00;
            bus.DDS_start <= state_nxt == START;
            if (grant) begin
                bus.DDS_freq       <= pick1 ? bus.r1_freq : bus.r0_freq;
                bus.DDS_delta_freq <= pick1 ? bus.r1_step : bus.r0_step;
                bus.DDS_delta_rate <= pick1 ? bus.r1_rate : bus.r0_rate;
            end
        end
    end

`ifdef DDS_LOAD_TIMEOUT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            err_tmo <= 1'b0;
        end else begin
            cnt     <= (state_nxt == state && (state == LOAD || state == RELEASE)) ? cnt + 1'b1 : '0;
            err_tmo <= err_tmo | (state_nxt == ABORT && state != ABORT);
        end
    end
`endif
endmodule

// File: tb/tb_dds_load_arb.sv
// tb_dds_load_arb: directed vector bench for dds_load_arb with a 96 MHz 4-cycle ACK responder
module tb_dds_load_arb;
    import dds_load_arb_pkg::*;

    typedef struct {
        int         idx;
        logic       st;
        chirp_cfg_t cfg;
        int         exp_win;
        int         exp_starts;
        chirp_cfg_t exp_cfg;
    } vec_t;

    logic       CLK = 1'b0;
    logic       clk96 = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       err_tmo;
    logic [3:0] ack_pipe;
    logic       ack_force = 1'b0;
    logic       ack_val = 1'b0;
    int         chk = 0;
    int         bad = 0;
    int         order_q[$];
    int         starts_q[$];
    chirp_cfg_t cf0, cf1;
    vec_t       vecs[4];

    dds_load_arb_if bus ();

    dds_load_arb dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .err_tmo (err_tmo)
    );

    always #10 CLK = ~CLK;
    always #5 clk96 = ~clk96;

    always @(posedge clk96 or negedge rst_n) begin
        if (!rst_n) ack_pipe <= 4'b0;
        else        ack_pipe <= {ack_pipe[2:0], bus.REQ};
    end

    assign bus.ACK = ack_force ? ack_val : ack_pipe[3];

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not end, got running required finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive_cfg();
        bus.r0_freq = cf0.freq;
        bus.r0_step = cf0.step;
        bus.r0_rate = cf0.rate;
        bus.r1_freq = cf1.freq;
        bus.r1_step = cf1.step;
        bus.r1_rate = cf1.rate;
    endtask

    // requester model: each side holds r_req until its done pulse, re-requesting while n remains
    task automatic run_reqs(input int n0, input int n1);
        int rem[2];
        int cyc;
        int st_cnt;
        int cur;
        chirp_cfg_t exp;
        rem[0] = n0;
        rem[1] = n1;
        order_q.delete();
        starts_q.delete();
        bus.r_req = {n1 > 0, n0 > 0};
        cyc = 0;
        st_cnt = 0;
        cur = -1;
        while ((rem[0] + rem[1] > 0 || busy) && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            if (bus.DDS_start) st_cnt++;
            if (bus.r_gnt != 2'b00 && cur < 0) begin
                cur = bus.r_gnt[1] ? 1 : 0;
                order_q.push_back(cur);
                st_cnt = 0;
                exp = cur == 1 ? cf1 : cf0;
                check("gnt_onehot", 64'($onehot(bus.r_gnt)), 64'd1);
                check("req_at_grant", bus.REQ, 1'b1);
                check("busy_at_grant", busy, 1'b1);
                check("dds_freq", bus.DDS_freq, exp.freq);
                check("dds_step", bus.DDS_delta_freq, exp.step);
                check("dds_rate", bus.DDS_delta_rate, exp.rate);
            end
            if (bus.r_done != 2'b00) begin
                check("done_vs_gnt", bus.r_done, cur == 1 ? 2'b10 : (cur == 0 ? 2'b01 : 2'b00));
                check("gnt_clr_at_done", bus.r_gnt, 2'b00);
                check("req_low_at_done", bus.REQ, 1'b0);
                starts_q.push_back(st_cnt);
                if (cur >= 0) begin
                    rem[cur]--;
                    if (rem[cur] == 0) bus.r_req[cur] = 1'b0;
                end
                cur = -1;
            end
        end
        check("run_in_budget", 64'(cyc < 2000), 64'd1);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int c;
        int sc;
        vecs[0] = '{0, 1'b1, {48'h0010_0000_0000, 48'h0000_0010_0000, 32'h0000_0100},
                    0, 1, {48'h0010_0000_0000, 48'h0000_0010_0000, 32'h0000_0100}};
        vecs[1] = '{0, 1'b0, {48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF},
                    0, 0, {48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF}};
        vecs[2] = '{1, 1'b1, {48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 32'h0000_0001},
                    1, 1, {48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 32'h0000_0001}};
        vecs[3] = '{1, 1'b0, {48'hA5A5_5A5A_1234, 48'h0000_0012_3456, 32'hDEAD_BEEF},
                    1, 0, {48'hA5A5_5A5A_1234, 48'h0000_0012_3456, 32'hDEAD_BEEF}};
        bus.r_req = 2'b00;
        bus.r_start = 2'b00;
        cf0 = '0;
        cf1 = '0;
        drive_cfg();

        repeat (3) @(negedge CLK);
        check("rst_req", bus.REQ, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_gnt", bus.r_gnt, 2'b00);
        check("rst_done", bus.r_done, 2'b00);
        check("rst_start", bus.DDS_start, 1'b0);
        check("rst_freq", bus.DDS_freq, 48'h0);
        check("rst_rate", bus.DDS_delta_rate, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_tmo, 1'b0);

        for (int i = 0; i < 4; i++) begin
            cf0 = vecs[i].idx == 0 ? vecs[i].cfg : ~vecs[i].cfg;
            cf1 = vecs[i].idx == 1 ? vecs[i].cfg : ~vecs[i].cfg;
            drive_cfg();
            bus.r_start[vecs[i].idx] = vecs[i].st;
            bus.r_start[1 - vecs[i].idx] = ~vecs[i].st;
            run_reqs(vecs[i].idx == 0 ? 1 : 0, vecs[i].idx == 1 ? 1 : 0);
            check("vec_ngrants", order_q.size(), 1);
            check("vec_winner", order_q.size() > 0 ? order_q[0] : -1, vecs[i].exp_win);
            check("vec_starts", starts_q.size() > 0 ? starts_q[0] : -1, vecs[i].exp_starts);
            cf0 = ~cf0;
            cf1 = ~cf1;
            drive_cfg();
            repeat (3) @(negedge CLK);
            check("hold_freq", bus.DDS_freq, vecs[i].exp_cfg.freq);
            check("hold_step", bus.DDS_delta_freq, vecs[i].exp_cfg.step);
            check("hold_rate", bus.DDS_delta_rate, vecs[i].exp_cfg.rate);
        end

        cf0 = vecs[0].cfg;
        cf1 = vecs[3].cfg;
        drive_cfg();
        bus.r_start = 2'b11;
        run_reqs(1, 1);
        check("both_n", order_q.size(), 2);
        check("both_first", order_q.size() > 0 ? order_q[0] : -1, 0);
        check("both_second", order_q.size() > 1 ? order_q[1] : -1, 1);
        check("both_starts0", starts_q.size() > 0 ? starts_q[0] : -1, 1);
        check("both_starts1", starts_q.size() > 1 ? starts_q[1] : -1, 1);

        bus.r_start = 2'b00;
        run_reqs(3, 1);
        check("starve_n", order_q.size(), 4);
        check("starve_g1", order_q.size() > 0 ? order_q[0] : -1, 0);
        check("starve_g2", order_q.size() > 1 ? order_q[1] : -1, 0);
        check("starve_g3", order_q.size() > 2 ? order_q[2] : -1, 1);
        check("starve_g4", order_q.size() > 3 ? order_q[3] : -1, 0);
        check("starve_nostart", starts_q.size() > 2 ? starts_q[2] : -1, 0);

        ack_force = 1'b1;
        ack_val = 1'b0;
        bus.r_start = 2'b01;
        bus.r_req = 2'b01;
        c = 0;
        while (!bus.REQ && c < 20) begin
            @(negedge CLK);
            c++;
        end
        check("stuck_req_rise", bus.REQ, 1'b1);
        c = 0;
        while (bus.REQ && c < 300) begin
            @(negedge CLK);
            c++;
        end
`ifdef DDS_LOAD_TIMEOUT_EN
        check("tmo_req_len", c, 255);
        check("tmo_err", err_tmo, 1'b1);
        sc = 0;
        c = 0;
        while (bus.r_done == 2'b00 && c < 20) begin
            @(negedge CLK);
            c++;
            if (bus.DDS_start) sc++;
        end
        check("tmo_done", bus.r_done, 2'b01);
        check("tmo_nostart", sc, 0);
        bus.r_req = 2'b00;
        @(negedge CLK);
        check("tmo_busy_after", busy, 1'b0);
        check("tmo_err_sticky", err_tmo, 1'b1);
`else
        sc = 0;
        check("noto_req_held", bus.REQ, 1'b1);
        check("noto_busy", busy, 1'b1);
        check("noto_err", err_tmo, 1'b0);
        check("noto_done", bus.r_done, 2'b00);
        bus.r_req = 2'b00;
`endif
        pulse_reset();
        check("reset_clears_err", err_tmo, 1'b0);

        bus.r_req = 2'b01;
        c = 0;
        while (!bus.REQ && c < 20) begin
            @(negedge CLK);
            c++;
        end
        check("load_req", bus.REQ, 1'b1);
        repeat (5) @(negedge CLK);
        #3;
        rst_n = 1'b0;
        ack_val = 1'b1;
        #1;
        check("async_rst_req", bus.REQ, 1'b0);
        check("async_rst_gnt", bus.r_gnt, 2'b00);
        check("async_rst_busy", busy, 1'b0);
        bus.r_req = 2'b00;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (4) @(negedge CLK);
        bus.r_req = 2'b01;
        repeat (10) @(negedge CLK);
        check("stale_ack_gnt", bus.r_gnt, 2'b00);
        check("stale_ack_req", bus.REQ, 1'b0);
        check("stale_ack_busy", busy, 1'b0);
        ack_force = 1'b0;
        cf0 = vecs[1].cfg;
        drive_cfg();
        run_reqs(1, 0);
        check("stale_then_gnt", order_q.size() > 0 ? order_q[0] : -1, 0);
        check("stale_then_start", starts_q.size() > 0 ? starts_q[0] : -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", chk, bad);
        $finish;
    end
endmodule
